// File: rtl/branch_resolve_stage.sv
// branch_resolve_stage
// Single-entry EX pipeline stage that resolves conditional branches.
// The held operands drive an external signed/unsigned comparator and its
// less-than result is consumed in the same cycle; equality is computed here.
// A valid/ready handshake on both sides lets the stage stall and be flushed.
module branch_resolve_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [2:0]        in_op,
    input  logic [31:0]       in_rj,
    input  logic [31:0]       in_rd,
    input  logic [ADDR_W-1:0] in_offs,
    input  logic              flush,
    output logic [31:0]       cmp_src1,
    output logic [31:0]       cmp_src2,
    output logic              cmp_sign,
    input  logic              cmp_res,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_taken,
    output logic [ADDR_W-1:0] out_target,
    output logic              br_redirect,
    output logic [ADDR_W-1:0] br_target
);

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_BEQ  = 3'd1;
    localparam logic [2:0] OP_BNE  = 3'd2;
    localparam logic [2:0] OP_BLT  = 3'd3;
    localparam logic [2:0] OP_BGE  = 3'd4;
    localparam logic [2:0] OP_BLTU = 3'd5;
    localparam logic [2:0] OP_BGEU = 3'd6;

    logic              valid_r;
    logic [ADDR_W-1:0] pc_r;
    logic [2:0]        op_r;
    logic [31:0]       rj_r;
    logic [31:0]       rd_r;
    logic [ADDR_W-1:0] offs_r;

    logic              accept_s;
    logic              pop_s;
    logic              eq_s;
    logic              taken_s;
    logic [ADDR_W-1:0] target_s;

    // Input handshake: a flush blocks acceptance; otherwise accept when empty or draining.
    always_comb begin
        in_ready = 1'b0;
        if (flush) begin
            in_ready = 1'b0;
        end else begin
            in_ready = !valid_r || out_ready;
        end
        accept_s = in_valid && in_ready;
        pop_s    = valid_r && out_ready;
    end

    // Occupancy bit: reset beats flush, flush beats the handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 1'b0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (accept_s) begin
            valid_r <= 1'b1;
        end else if (pop_s) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Held instruction fields; cleared on reset so idle outputs are never X.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r   <= '0;
            op_r   <= OP_NONE;
            rj_r   <= 32'd0;
            rd_r   <= 32'd0;
            offs_r <= '0;
        end else if (accept_s) begin
            pc_r   <= in_pc;
            op_r   <= in_op;
            rj_r   <= in_rj;
            rd_r   <= in_rd;
            offs_r <= in_offs;
        end else begin
            pc_r   <= pc_r;
            op_r   <= op_r;
            rj_r   <= rj_r;
            rd_r   <= rd_r;
            offs_r <= offs_r;
        end
    end

    // Comparator operands come straight from the held entry; only blt/bge compare signed.
    always_comb begin
        cmp_src1 = rj_r;
        cmp_src2 = rd_r;
        cmp_sign = (op_r == OP_BLT) || (op_r == OP_BGE);
        eq_s     = (rj_r == rd_r);
    end

    // Branch decision from local equality and the same-cycle comparator result.
    always_comb begin
        taken_s = 1'b0;
        case (op_r)
            OP_BEQ:  taken_s = eq_s;
            OP_BNE:  taken_s = !eq_s;
            OP_BLT:  taken_s = cmp_res;
            OP_BLTU: taken_s = cmp_res;
            OP_BGE:  taken_s = !cmp_res;
            OP_BGEU: taken_s = !cmp_res;
            default: taken_s = 1'b0;
        endcase
    end

    // Next-PC selection; address arithmetic wraps silently.
    always_comb begin
        target_s = '0;
        if (taken_s) begin
            target_s = pc_r + offs_r;
        end else begin
            target_s = pc_r + ADDR_W'(32'd4);
        end
    end

    // Output side: redirect only on the handoff cycle of a taken branch that is not flushed.
    always_comb begin
        out_valid   = valid_r;
        out_pc      = pc_r;
        out_taken   = taken_s;
        out_target  = target_s;
        br_target   = target_s;
        br_redirect = valid_r && out_ready && taken_s && !flush;
    end

endmodule

// File: tb/tb_branch_resolve_stage.sv
// tb_branch_resolve_stage
// Directed bench with a scoreboard queue: expected results are pushed when the
// model accepts an instruction and compared while the entry is resident.
module tb_branch_resolve_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [2:0]  in_op;
    logic [31:0] in_rj;
    logic [31:0] in_rd;
    logic [31:0] in_offs;
    logic        flush;
    logic [31:0] cmp_src1;
    logic [31:0] cmp_src2;
    logic        cmp_sign;
    logic        cmp_res;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic        out_taken;
    logic [31:0] out_target;
    logic        br_redirect;
    logic [31:0] br_target;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  op;
        logic [31:0] rj;
        logic [31:0] rd;
        logic        taken;
        logic [31:0] target;
    } ent_t;

    ent_t sb[$];

    branch_resolve_stage #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_op(in_op), .in_rj(in_rj), .in_rd(in_rd), .in_offs(in_offs),
        .flush(flush),
        .cmp_src1(cmp_src1), .cmp_src2(cmp_src2), .cmp_sign(cmp_sign), .cmp_res(cmp_res),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_taken(out_taken), .out_target(out_target),
        .br_redirect(br_redirect), .br_target(br_target)
    );

    // External comparator: signed or unsigned less-than on the driven operands.
    assign cmp_res = cmp_sign ? ($signed(cmp_src1) < $signed(cmp_src2)) : (cmp_src1 < cmp_src2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ent_t model(input logic [31:0] pc, input logic [2:0] op,
                                   input logic [31:0] rj, input logic [31:0] rd,
                                   input logic [31:0] offs);
        ent_t e;
        e.pc = pc; e.op = op; e.rj = rj; e.rd = rd;
        case (op)
            3'd1:    e.taken = (rj == rd);
            3'd2:    e.taken = (rj != rd);
            3'd3:    e.taken = ($signed(rj) < $signed(rd));
            3'd4:    e.taken = !($signed(rj) < $signed(rd));
            3'd5:    e.taken = (rj < rd);
            3'd6:    e.taken = !(rj < rd);
            default: e.taken = 1'b0;
        endcase
        e.target = e.taken ? (pc + offs) : (pc + 32'd4);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] pc,
                         input logic [31:0] rj, input logic [31:0] rd, input logic [31:0] offs);
        in_valid = v; in_op = op; in_pc = pc; in_rj = rj; in_rd = rd; in_offs = offs;
    endtask

    // One clock: check at negedge, then advance the model at the posedge.
    task automatic cycle();
        logic mv;
        logic exp_rdy;
        ent_t e;
        @(negedge clk);
        mv = (sb.size() != 0);
        exp_rdy = !flush && (!mv || out_ready);
        chk("out_valid", {31'd0, out_valid}, {31'd0, mv});
        if (!reset) chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        if (mv) begin
            e = sb[0];
            chk("out_pc", out_pc, e.pc);
            chk("out_taken", {31'd0, out_taken}, {31'd0, e.taken});
            chk("out_target", out_target, e.target);
            chk("br_target", br_target, e.target);
            chk("cmp_src1", cmp_src1, e.rj);
            chk("cmp_src2", cmp_src2, e.rd);
            chk("cmp_sign", {31'd0, cmp_sign}, {31'd0, (e.op == 3'd3) || (e.op == 3'd4)});
            chk("br_redirect", {31'd0, br_redirect},
                {31'd0, e.taken && out_ready && !flush && !reset});
        end else begin
            chk("br_redirect_idle", {31'd0, br_redirect}, 32'd0);
        end
        @(posedge clk);
        if (reset) begin
            sb.delete();
        end else begin
            if (mv && (out_ready || flush)) void'(sb.pop_front());
            if (in_valid && exp_rdy) sb.push_back(model(in_pc, in_op, in_rj, in_rd, in_offs));
        end
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        @(posedge clk); #1;
        cycle();
        reset = 1'b0;
        cycle();  // reset state: out_valid=0, in_ready=1, no redirect

        // beq taken
        drive(1'b1, 3'd1, 32'h1C000000, 32'h5, 32'h5, 32'h10);
        cycle();
        // blt signed -1 < 1 taken, then bltu same operands not taken
        drive(1'b1, 3'd3, 32'h1C000100, 32'hFFFFFFFF, 32'h1, 32'h40);
        cycle();
        drive(1'b1, 3'd5, 32'h1C000200, 32'hFFFFFFFF, 32'h1, 32'h40);
        cycle();
        // bge / bgeu with equal operands: both taken
        drive(1'b1, 3'd4, 32'h1C000300, 32'h80000000, 32'h80000000, 32'hFFFFFFF0);
        cycle();
        drive(1'b1, 3'd6, 32'h1C000400, 32'h80000000, 32'h80000000, 32'h20);
        cycle();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        cycle();

        // stall: resident taken beq, 3 cycles of backpressure with a waiting instruction
        drive(1'b1, 3'd1, 32'h1C001000, 32'h7, 32'h7, 32'h80);
        cycle();
        out_ready = 1'b0;
        drive(1'b1, 3'd2, 32'h1C002000, 32'h1, 32'h2, 32'h8);
        cycle(); cycle(); cycle();
        out_ready = 1'b1;
        cycle();  // handoff with single redirect, waiting bne accepted
        drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        cycle();

        // flush: taken bne resident, simultaneous input rejected
        drive(1'b1, 3'd2, 32'h1C003000, 32'h1, 32'h2, 32'h100);
        cycle();
        flush = 1'b1;
        drive(1'b1, 3'd1, 32'h1C004000, 32'h3, 32'h3, 32'h4);
        cycle();
        flush = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        cycle();  // out_valid must be 0

        // wrap and reserved op
        drive(1'b1, 3'd0, 32'hFFFFFFFC, 32'h1, 32'h1, 32'h10);
        cycle();
        drive(1'b1, 3'd7, 32'h1C005000, 32'h1, 32'h1, 32'h10);
        cycle();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        cycle();

        // reset during a stall drops the entry
        drive(1'b1, 3'd1, 32'h1C006000, 32'h9, 32'h9, 32'h30);
        cycle();
        out_ready = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0; out_ready = 1'b1;
        cycle();

        // mixed traffic with random backpressure and operands
        for (int i = 0; i < 40; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom,
                  32'($urandom_range(0, 3)) - 32'd1, 32'($urandom_range(0, 3)) - 32'd1,
                  $urandom & 32'hFFFFFFFC);
            flush = ($urandom_range(0, 9) == 0);
            cycle();
        end
        flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        cycle(); cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
